// File: rtl/logs_map_iterator_pkg.sv
// Shared definitions for the logistic-map iterator: default sizing, the
// iteration FSM encoding and the reset value of x (0.5).
package logs_map_iterator_pkg;

   localparam int FRAC_DEF     = 8;
   localparam int ITER_LEN_DEF = 100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL1 = 2'd1,
      MUL2 = 2'd2,
      DONE = 2'd3
   } state_t;

   function automatic int x_init(input int frac);
      return 1 << (frac - 1);
   endfunction

endpackage

// File: rtl/logs_serial_mult.sv
// Unsigned LSB-first shift-add multiplier: one partial product per enabled
// cycle, B_W cycles per product. start takes priority over an ongoing multiply.
module logs_serial_mult #(
   parameter int A_W = 10,
   parameter int B_W = 10
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               start,
   input  logic [A_W-1:0]     a,
   input  logic [B_W-1:0]     b,
   output logic               busy,
   output logic [A_W+B_W-1:0] product
);

   localparam int STEP_W = $clog2(B_W + 1);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(B_W - 1);

   logic [A_W-1:0]    a_l;
   logic [STEP_W-1:0] step;
   logic [A_W:0]      sum;

   // Upper half accumulates a while the multiplier bits shift out of the low half.
   always_comb begin
      sum = {1'b0, product[A_W+B_W-1:B_W]} + (product[0] ? {1'b0, a_l} : '0);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         product <= '0;
         a_l     <= '0;
         step    <= '0;
         busy    <= 1'b0;
      end else if (start) begin
         product <= {{A_W{1'b0}}, b};
         a_l     <= a;
         step    <= '0;
         busy    <= 1'b1;
      end else if (en && busy) begin
         product <= {sum, product[B_W-1:1]};
         step    <= step + STEP_W'(1);
         if (step == STEP_LAST) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/logs_map_iterator.sv
// Logistic map x' = r*x*(1-x) in unsigned fixed point, one new x every ITER_LEN
// clocks, computed with a single shared serial multiplier.
module logs_map_iterator
   import logs_map_iterator_pkg::*;
#(
   parameter int FRAC     = FRAC_DEF,
   parameter int ITER_LEN = ITER_LEN_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            hold,
   input  logic [FRAC+1:0] r,
   output logic [FRAC-1:0] x,
   output logic            next_ready
);

   localparam int OP_W   = FRAC + 2;
   localparam int PROD_W = 2 * OP_W;
   localparam int CNT_W  = $clog2(ITER_LEN);
   localparam int MC_W   = $clog2(FRAC + 3);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_LEN - 1);
   localparam logic [MC_W-1:0]  MUL_LAST = MC_W'(FRAC + 1);
   localparam logic [FRAC-1:0]  X_INIT   = FRAC'(x_init(FRAC));

   if (ITER_LEN < 2 * FRAC + 6) begin : g_iter_len_check
      $error("ITER_LEN too short to fit both serial multiplies");
   end

   state_t            state, state_next;
   logic [CNT_W-1:0]  cnt;
   logic [MC_W-1:0]   mul_cnt;
   logic [OP_W-1:0]   r_l;
   logic              mult_start;
   logic              commit;
   logic [OP_W-1:0]   mult_a, mult_b;
   logic              mult_busy;
   logic [PROD_W-1:0] mult_product;
   logic [FRAC:0]     one_minus_x;
   logic [FRAC-1:0]   p, y;
   logic              unused_mult;

   logs_serial_mult #(.A_W(OP_W), .B_W(OP_W)) u_mult (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (!hold),
      .start   (mult_start),
      .a       (mult_a),
      .b       (mult_b),
      .busy    (mult_busy),
      .product (mult_product)
   );

   // The first operand (1-x) is only FRAC+1 bits, so after FRAC+1 steps the
   // product still sits one position left of its final alignment.
   assign one_minus_x = {1'b1, {FRAC{1'b0}}} - {1'b0, x};
   assign p           = mult_product[2*FRAC:FRAC+1];
   assign y           = mult_product[2*FRAC-1:FRAC];
   assign unused_mult = ^{mult_busy, mult_product[PROD_W-1:2*FRAC+1], mult_product[FRAC-1:0]};

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else if (!hold) state <= state_next;
   end

   // NOTE: every signal assigned in a combinational block gets a default first,
   // so no path through the case can leave it unassigned and infer a latch.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (cnt == '0) state_next = MUL1;
         MUL1:    if (mul_cnt == MUL_LAST) state_next = MUL2;
         MUL2:    if (mul_cnt == MUL_LAST) state_next = DONE;
         DONE:    if (cnt == CNT_LAST) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      mult_start = 1'b0;
      mult_a     = '0;
      mult_b     = '0;
      commit     = 1'b0;
      unique case (state)
         IDLE: begin
            mult_start = !hold && (cnt == '0);
            mult_a     = OP_W'(x);
            mult_b     = OP_W'(one_minus_x);
         end
         MUL1: begin
            mult_start = !hold && (mul_cnt == MUL_LAST);
            mult_a     = OP_W'(p);
            mult_b     = r_l;
         end
         DONE:    commit = !hold && (cnt == CNT_LAST);
         default: ;
      endcase
   end

   // NOTE: only control and output registers are reset; the datapath holds no
   // memory arrays, so every flop here has a defined reset value.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt        <= '0;
         mul_cnt    <= '0;
         r_l        <= '0;
         x          <= X_INIT;
         next_ready <= 1'b0;
      end else begin
         next_ready <= commit;
         if (!hold) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
            if (state_next != state) mul_cnt <= '0;
            else if (state == MUL1 || state == MUL2) mul_cnt <= mul_cnt + MC_W'(1);
            if (state == IDLE && cnt == '0) r_l <= r;
            // A zero result is nudged to 1 LSB to keep the map off its absorbing point.
            if (commit) x <= (y == '0) ? FRAC'(1) : y;
         end
      end
   end

endmodule
